// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared types and constants for the PC fetch sequencer
package pc_fetch_pkg;

  // Next-PC source selected by the controller
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_TARGET = 2'b01,
    PC_JALR   = 2'b10
  } pc_src_e;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;

  // Only branch/jal and jalr sources move the PC off the sequential path; 2'b11 falls back to sequential
  function automatic logic is_redirect_src(input logic [1:0] src);
    return (pc_src_e'(src) == PC_TARGET) || (pc_src_e'(src) == PC_JALR);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_redirect_mux.sv
// rtl/pc_fetch_unit_redirect_mux.sv - combinational redirect decode and target alignment
module pc_redirect_mux
  import pc_fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            ex_valid,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic            redirect,
  output logic [XLEN-1:0] target,
  output logic            misalign_bit
);

  // Keep only whole-instruction address bits; bit1 is reported separately as a misalignment
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0] JALR_MASK = ~XLEN'(1);

  logic [XLEN-1:0] raw_target;

  // Pick the raw target, then derive the aligned PC and the misalignment bit
  always_comb begin
    raw_target   = branch_target;
    redirect     = ex_valid & is_redirect_src(pc_src);
    if (pc_src_e'(pc_src) == PC_JALR) begin
      raw_target = jalr_target & JALR_MASK;
    end
    target       = raw_target & WORD_MASK;
    misalign_bit = raw_target[1];
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, imem fetch sequencer and IF/ID output stage
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic            flush,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next_seq;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic            misalign_bit;
  logic            accept;

  pc_redirect_mux #(
    .XLEN(XLEN)
  ) u_redirect_mux (
    .ex_valid     (ex_valid),
    .pc_src       (pc_src),
    .branch_target(branch_target),
    .jalr_target  (jalr_target),
    .redirect     (redirect),
    .target       (target),
    .misalign_bit (misalign_bit)
  );

  // Requests stall while the IF/ID slot is full and not being drained
  assign imem_req    = (state == REQ) & (~if_valid | if_ready);
  assign imem_addr   = pc;
  assign pc_next_seq = pc + STEP;
  assign accept      = imem_req & imem_ack & ~redirect;

  // Fetch FSM, PC register, IF/ID payload and sticky misalignment flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
      flush       <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      flush <= redirect;
      if (redirect) begin
        misaligned <= misaligned | misalign_bit;
      end

      case (state)
        IDLE: begin
          if (redirect) pc <= target;
          state <= REQ;
        end
        REQ: begin
          if (redirect) begin
            pc <= target;
            // A request still in flight returns wrong-path data that must be swallowed
            if (imem_req && !imem_ack) state <= DROP;
          end else if (accept) begin
            pc <= pc_next_seq;
          end
        end
        DROP: begin
          if (redirect) pc <= target;
          // The stale response closes the old request, so fetching can restart
          if (imem_ack) state <= REQ;
        end
        default: state <= IDLE;
      endcase

      if (redirect) begin
        if_valid <= 1'b0;
      end else if (accept) begin
        if_valid    <= 1'b1;
        if_pc       <= pc;
        if_pc_plus4 <= pc_next_seq;
      end else if (if_valid && if_ready) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule
